// File: rtl/base_rrlock_arb.sv
// N-way packet-locking arbiter: fixed-priority or round-robin selection, grant held
// from first beat to end-of-packet, single registered output stage.
module base_rrlock_arb #(
  parameter int ways  = 4,
  parameter int width = 64,
  parameter int ptrw  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_mode,
  input  logic [0:ways-1]       i_v,
  output logic [0:ways-1]       i_r,
  input  logic [0:ways*width-1] i_d,
  input  logic [0:ways-1]       i_e,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [0:width-1]      o_d,
  output logic                  o_e,
  output logic [0:ways-1]       o_s
);

  logic                o_v_q, o_v_d;
  logic [0:width-1]    o_d_q, o_d_d;
  logic                o_e_q, o_e_d;
  logic [0:ways-1]     o_s_q, o_s_d;
  logic                lock_q, lock_d;
  logic [ptrw-1:0]     lway_q, lway_d;
  logic [ptrw-1:0]     ptr_q, ptr_d;

  logic                ld;
  logic                win_v;
  logic [ptrw-1:0]     win_idx;
  logic [ptrw-1:0]     rr_idx [ways];
  logic [0:width-1]    way_d  [ways];

  assign ld = ~o_v_q | o_r;

  // rr_idx[j] is the way visited j-th when scanning round-robin from ptr.
  for (genvar gi = 0; gi < ways; gi++) begin : g_way
    logic [ptrw:0] sum;
    assign sum         = {1'b0, ptr_q} + (ptrw+1)'(gi);
    assign rr_idx[gi]  = (sum >= (ptrw+1)'(ways)) ? ptrw'(sum - (ptrw+1)'(ways)) : ptrw'(sum);
    assign way_d[gi]   = i_d[gi*width +: width];
    assign i_r[gi]     = ld & win_v & (win_idx == ptrw'(gi));
  end

  // Scans run from the lowest-priority candidate upward so the last hit wins.
  always_comb begin : select
    win_v   = 1'b0;
    win_idx = '0;
    if (lock_q) begin
      win_v   = i_v[lway_q];
      win_idx = lway_q;
    end else if (!i_mode) begin
      for (int k = ways-1; k >= 0; k--) begin
        if (i_v[k]) begin
          win_v   = 1'b1;
          win_idx = ptrw'(k);
        end
      end
    end else begin
      for (int j = ways-1; j >= 0; j--) begin
        if (i_v[rr_idx[j]]) begin
          win_v   = 1'b1;
          win_idx = rr_idx[j];
        end
      end
    end
  end

  always_comb begin : next_state
    o_v_d  = o_v_q;
    o_d_d  = o_d_q;
    o_e_d  = o_e_q;
    o_s_d  = o_s_q;
    lock_d = lock_q;
    lway_d = lway_q;
    ptr_d  = ptr_q;
    if (ld) begin
      o_v_d = win_v;
      if (win_v) begin
        o_d_d          = way_d[win_idx];
        o_e_d          = i_e[win_idx];
        o_s_d          = '0;
        o_s_d[win_idx] = 1'b1;
        lock_d         = ~i_e[win_idx];
        if (!i_e[win_idx]) begin
          lway_d = win_idx;
        end
        if (i_e[win_idx] && i_mode) begin
          ptr_d = (win_idx == ptrw'(ways-1)) ? '0 : win_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_v_q  <= 1'b0;
      o_d_q  <= '0;
      o_e_q  <= 1'b0;
      o_s_q  <= '0;
      lock_q <= 1'b0;
      lway_q <= '0;
      ptr_q  <= '0;
    end else begin
      o_v_q  <= o_v_d;
      o_d_q  <= o_d_d;
      o_e_q  <= o_e_d;
      o_s_q  <= o_s_d;
      lock_q <= lock_d;
      lway_q <= lway_d;
      ptr_q  <= ptr_d;
    end
  end

  assign o_v = o_v_q;
  assign o_d = o_d_q;
  assign o_e = o_e_q;
  assign o_s = o_s_q;

endmodule

// File: tb/tb_base_rrlock_arb.sv
// Scoreboard bench for base_rrlock_arb: directed vectors push expected beats,
// a monitor pops and compares as beats leave; a random soak checks ordering properties.
module tb_base_rrlock_arb;
  localparam int W  = 4;
  localparam int DW = 64;
  localparam int PW = 2;
  localparam int NV = 27;
  localparam int NSOAK = 3000;

  logic              clk = 1'b0;
  logic              reset, i_mode, o_v, o_r, o_e;
  logic [0:W-1]      i_v, i_r, i_e, o_s;
  logic [0:W*DW-1]   i_d;
  logic [0:DW-1]     o_d;

  always #5 clk = ~clk;

  base_rrlock_arb #(.ways(W), .width(DW), .ptrw(PW)) dut (
    .clk(clk), .reset(reset), .i_mode(i_mode),
    .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_e(i_e),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_e(o_e), .o_s(o_s)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
    logic [0:W-1]  s;
  } beat_t;

  typedef struct packed {
    logic         rst;
    logic         mode;
    logic [0:W-1] iv;
    logic [0:W-1] ie;
    logic         orr;
    logic [0:W-1] ir;
    logic         ov;
  } vec_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    soak   = 1'b0;
  int    sout [W];
  vec_t  vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pay(input int k, input int n);
    return (DW'(k) << 56) | DW'(n);
  endfunction

  function automatic logic [0:W-1] onehot(input int k);
    logic [0:W-1] s;
    s    = '0;
    s[k] = 1'b1;
    return s;
  endfunction

  // Monitor: compares each beat as it leaves (o_v & o_r) and checks hold under backpressure.
  initial begin
    logic [DW-1:0] od, prev_d;
    logic          prev_e;
    logic [0:W-1]  prev_s, pkt_src;
    bit            hold_p, in_pkt;
    beat_t         b;
    int            wk;
    hold_p = 1'b0;
    in_pkt = 1'b0;
    pkt_src = '0;
    prev_d = '0; prev_e = 1'b0; prev_s = '0;
    for (int k = 0; k < W; k++) sout[k] = 0;
    forever begin
      @(negedge clk);
      od = o_d;
      if (reset) begin
        hold_p = 1'b0;
        in_pkt = 1'b0;
      end else begin
        if (hold_p) begin
          check("hold o_d", od, prev_d);
          check("hold o_e", o_e, prev_e);
          check("hold o_s", o_s, prev_s);
        end
        if (o_v && o_r) begin
          if (!soak) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected beat: actual o_d=%0h o_s=%b required none", od, o_s);
            end else begin
              b = exp_q.pop_front();
              check("beat o_d", od, b.d);
              check("beat o_e", o_e, b.e);
              check("beat o_s", o_s, b.s);
            end
          end else begin
            check("soak o_s onehot", $onehot(o_s), 1);
            wk = 0;
            for (int k = 0; k < W; k++) if (o_s[k]) wk = k;
            check("soak way tag", od[63:56], wk);
            check("soak order", od[55:0], sout[wk]);
            sout[wk]++;
            if (in_pkt) check("soak no interleave", o_s, pkt_src);
            in_pkt  = !o_e;
            pkt_src = o_s;
          end
        end
        hold_p = o_v && !o_r;
        prev_d = od;
        prev_e = o_e;
        prev_s = o_s;
      end
    end
  end

  initial begin
    vec_t         v;
    logic [0:W-1] acc;
    int           sseq [W];

    //        rst   mode  iv       ie       o_r   exp i_r  exp o_v
    vecs = '{
      '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0},  // fixed priority
      '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1},
      '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1},
      '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1},  // round robin from ptr 0
      '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1},
      '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1},
      '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1},
      '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1},  // wrap
      '{1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1},  // way 2 locks
      '{1'b0, 1'b0, 4'b1010, 4'b1000, 1'b1, 4'b0010, 1'b1},
      '{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b1},  // way 2 gap, way 0 blocked
      '{1'b0, 1'b0, 4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b0},  // bubble, eop
      '{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1},
      '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1},  // backpressure
      '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1},
      '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1},
      '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1},
      '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1},
      '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1},
      '{1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0},  // ptr kept at 1, way 1 locks
      '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1},  // mode switch keeps lock
      '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b1},
      '{1'b0, 1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1},  // way 2 locks
      '{1'b1, 1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1},  // reset mid-packet
      '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0},  // unlocked, ptr 0
      '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1},
      '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0}
    };

    reset  = 1'b1;
    i_mode = 1'b0;
    i_v    = '0;
    i_e    = '0;
    i_d    = '0;
    o_r    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset o_v", o_v, 0);
    check("reset o_d", o_d, 0);
    check("reset o_e", o_e, 0);
    check("reset o_s", o_s, 0);
    check("reset i_r", i_r, 0);

    for (int n = 0; n < NV; n++) begin
      v = vecs[n];
      @(posedge clk); #1;
      reset  = v.rst;
      i_mode = v.mode;
      i_v    = v.iv;
      i_e    = v.ie;
      o_r    = v.orr;
      for (int k = 0; k < W; k++) i_d[k*DW +: DW] = pay(k, n);
      @(negedge clk); #1;
      if (v.rst) begin
        exp_q.delete();
      end else begin
        check($sformatf("vec%0d i_r", n), i_r, v.ir);
        check($sformatf("vec%0d o_v", n), o_v, v.ov);
        for (int k = 0; k < W; k++) begin
          if (v.ir[k]) exp_q.push_back('{pay(k, n), v.ie[k], onehot(k)});
        end
      end
    end
    check("directed queue drained", exp_q.size(), 0);

    soak = 1'b1;
    acc  = '0;
    for (int k = 0; k < W; k++) sseq[k] = 0;
    i_v = '0;
    for (int c = 0; c < NSOAK; c++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      if ($urandom_range(0, 15) == 0) i_mode = ~i_mode;
      o_r = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < W; k++) begin
        if (acc[k]) begin
          sseq[k]++;
          i_v[k] = 1'b0;
        end
        if (!i_v[k]) begin
          i_v[k] = ($urandom_range(0, 2) != 0);
          i_e[k] = ($urandom_range(0, 2) == 0);
          i_d[k*DW +: DW] = pay(k, sseq[k]);
        end
      end
      @(negedge clk); #1;
      check("soak i_r onehot0", $onehot0(i_r), 1);
      acc = i_v & i_r;
    end
    for (int k = 0; k < W; k++) if (acc[k]) sseq[k]++;
    @(posedge clk); #1;
    i_v = '0;
    o_r = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int k = 0; k < W; k++) check($sformatf("soak way%0d beat count", k), sout[k], sseq[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
